seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing scan controller for an N-digit common-anode seven-segment display.
- Holds a frame-stable display register, loaded through a valid/ready handshake.
- Walks the digits one at a time, with a guard gap between digits to suppress ghosting.
- Drives the active-low anode and decimal-point lines.
- Emits the current digit's 4-bit value on digit_nib, which the team's 4-bit-to-7-segment decoder (instantiated beside this block at board top level) turns into segment patterns.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (>=1).
- DIGIT_CYCLES, 100000: clk cycles each digit is driven per frame (>=1).
- GUARD_CYCLES, 1000: clk cycles all anodes are off between digit slots (>=0; 0 removes the guard state).

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst_n, input, 1: synchronous active-low reset, sampled on the rising edge of clk.
- load_valid, input, 1: new display value offered.
- load_data, input, 4*NUM_DIGITS: nibble per digit; digit i = load_data[4*i+3:4*i].
- load_dp, input, NUM_DIGITS: decimal point per digit, 1 = lit.
- load_ready, output, 1: high when the pending slot is empty.
- blank_mask, input, NUM_DIGITS: 1 = digit i kept dark (live input, not part of load).
- digit_nib, output, 4: value of the digit currently driven, to the decoder S input.
- an, output, NUM_DIGITS: anode enables, active-low.
- dp, output, 1: decimal point, active-low.
- frame_done, output, 1: one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - an = all 1, dp = 1, digit_nib = 0, frame_done = 0, load_ready = 1.
  - Display register = 0, dp register = 0, pending slot empty (any pending value discarded).
  - digit_idx = 0, cycle counter = 0, state = GUARD (DRIVE when GUARD_CYCLES=0).
  - Reset mid-frame takes effect on that edge; there is no partial completion.
- FSM, 2 states:
  - GUARD: lasts GUARD_CYCLES cycles, an = all 1; then go to DRIVE for digit_idx.
  - DRIVE: lasts DIGIT_CYCLES cycles; then go to GUARD and set digit_idx = digit_idx+1, wrapping NUM_DIGITS-1 -> 0.
- Cycle counter width is clog2 of max(DIGIT_CYCLES, GUARD_CYCLES, 2). It clears on every state change.
- All outputs are registered and change on the same edge as the state transition.
- On the edge entering DRIVE for digit i:
  - digit_nib = disp_reg[4*i+3:4*i].
  - dp = ~dp_reg[i].
  - an = all 1 with bit i = 0, unless blank_mask[i] = 1, in which case an = all 1.
  - blank_mask is sampled only on this edge and held for the whole slot.
- In GUARD, digit_nib and dp hold their last values; only an is forced off.
- Frame boundary is the edge leaving DRIVE of digit NUM_DIGITS-1. On that edge:
  - frame_done = 1 for exactly one cycle.
  - If the pending slot is full: disp_reg/dp_reg take the pending contents and the slot empties (load_ready = 1 the next cycle).
- Frame period = NUM_DIGITS*(DIGIT_CYCLES+GUARD_CYCLES) cycles.
- Handshake:
  - load_ready = ~pending_full.
  - Transfer occurs when load_valid & load_ready at a rising edge; the slot fills and load_ready = 0 from the next cycle.
  - load_valid with load_ready = 0 is ignored; the requester holds it.
- Simultaneous transfer and frame boundary: the drain of the old pending value and the capture of the new one both happen on that edge. The new value waits for the following boundary; there is no bypass to disp_reg.
- Latency: an accepted value is first shown in the DRIVE of digit 0 after the next frame boundary. It never changes mid-frame.
- NUM_DIGITS = 1: digit_idx stays 0, and every DRIVE exit is a frame boundary.

Decomposition:
- Shared package scan_pkg: state enum (GUARD, DRIVE) and a digit-nibble width constant NIB_W = 4.
- One natural sub-module, scan_timer: a loadable down-counter with terminal-count output, reused for both GUARD and DRIVE durations.
- The decoder stays outside; this block never produces segment patterns.

Test Plan:
(NUM_DIGITS=4, DIGIT_CYCLES=4, GUARD_CYCLES=1 unless stated.)
1. Reset: hold rst_n=0 for 2 edges -> an=4'hF, dp=1, digit_nib=0, load_ready=1, frame_done=0. Release -> 1 guard cycle (an=F), then an=4'b1110 for 4 cycles, F for 1, 4'b1101 for 4, and so on; frame_done pulses every 20 cycles.
2. Load load_data=16'h1234, load_dp=4'b0001 mid-frame -> load_ready=0 next cycle; digits still show 0 until frame_done. Next frame: digit0 nib=4 with dp=0, digit1=3, digit2=2, digit3=1, each with dp=1; load_ready=1 the cycle after the boundary.
3. Second load 16'hABCD held with load_valid=1 while load_ready=0 -> not accepted until after the boundary; shown one full frame after 16'h1234. A load coinciding with the frame_done edge -> shown only after the following boundary.
4. blank_mask=4'b0100 -> an stays 4'hF during the digit-2 slot while the other digits scan. Set blank_mask while digit 1 is driven -> takes effect at the digit-2 slot, not mid-slot.
5. Assert rst_n=0 mid-DRIVE of digit 2 with a pending value -> next edge returns all reset values, disp_reg=0, pending discarded, load_ready=1.
6. GUARD_CYCLES=0 -> an steps directly 1110 -> 1101 -> 1011 -> 0111; frame_done every 16 cycles.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package scan_pkg;

  localparam int NIB_W = 4;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  function automatic int cnt_width(input int digit_cycles, input int guard_cycles);
    int m;
    m = 2;
    if (digit_cycles > m) m = digit_cycles;
    if (guard_cycles > m) m = guard_cycles;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-value load handshake between a requester and the scan controller.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import scan_pkg::*;

  logic                        load_valid;
  logic [NIB_W*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]       load_dp;
  logic                        load_ready;

  modport master (
    output load_valid,
    output load_data,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_dp,
    output load_ready
  );

endinterface

// File: rtl/seven_seg_scan_ctrl_scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module scan_timer #(
  parameter int             W       = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= RST_VAL;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Shows a frame-stable value; new values are swapped in only at frame boundaries.
module seven_seg_scan_ctrl
  import scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scan_ctrl_if.slave  ld,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [NIB_W-1:0]      digit_nib,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int CNT_W  = cnt_width(DIGIT_CYCLES, GUARD_CYCLES);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DATA_W = NIB_W * NUM_DIGITS;

  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] RST_LOAD   = (GUARD_CYCLES > 0) ? GUARD_LOAD : DRIVE_LOAD;
  localparam scan_state_t      RST_STATE  = (GUARD_CYCLES > 0) ? GUARD : DRIVE;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic                  tc;
  logic [CNT_W-1:0]      timer_load_val;
  logic                  boundary, enter_drive, enter_guard;
  logic [NUM_DIGITS-1:0] sel_vec;

  logic [DATA_W-1:0]     disp_reg, disp_next;
  logic [NUM_DIGITS-1:0] dpm_reg, dpm_next;
  logic [DATA_W-1:0]     pend_data_reg;
  logic [NUM_DIGITS-1:0] pend_dp_reg;
  logic                  pend_full_reg;
  logic                  xfer;

  logic [NIB_W-1:0]      nib_reg, nib_next;
  logic                  dp_out_reg, dp_out_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic                  fd_reg;

  // One timer serves both slot types; it is reloaded with the next slot's length at every terminal count.
  assign timer_load_val = (state_next == DRIVE) ? DRIVE_LOAD : GUARD_LOAD;

  scan_timer #(
    .W       (CNT_W),
    .RST_VAL (RST_LOAD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tc),
    .load_val (timer_load_val),
    .tc       (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= RST_STATE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    boundary    = 1'b0;
    enter_drive = 1'b0;
    enter_guard = 1'b0;
    if (tc) begin
      if (state_reg == GUARD) begin
        state_next  = DRIVE;
        enter_drive = 1'b1;
      end else begin
        boundary = (idx_reg == LAST_IDX);
        idx_next = boundary ? '0 : idx_reg + 1'b1;
        if (GUARD_CYCLES > 0) begin
          state_next  = GUARD;
          enter_guard = 1'b1;
        end else begin
          enter_drive = 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
      assign sel_vec[gi] = (idx_next == IDX_W'(gi));
    end
  endgenerate

  // Without a guard slot the boundary edge also enters digit 0, so the new frame value is used directly.
  always_comb begin
    xfer        = ld.load_valid & ~pend_full_reg;
    disp_next   = disp_reg;
    dpm_next    = dpm_reg;
    an_next     = an_reg;
    nib_next    = nib_reg;
    dp_out_next = dp_out_reg;
    if (boundary && pend_full_reg) begin
      disp_next = pend_data_reg;
      dpm_next  = pend_dp_reg;
    end
    if (enter_drive) begin
      nib_next    = disp_next[idx_next*NIB_W +: NIB_W];
      dp_out_next = ~dpm_next[idx_next];
      an_next     = ~(sel_vec & ~blank_mask);
    end else if (enter_guard) begin
      an_next = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_reg      <= '0;
      dpm_reg       <= '0;
      pend_data_reg <= '0;
      pend_dp_reg   <= '0;
      pend_full_reg <= 1'b0;
      nib_reg       <= '0;
      dp_out_reg    <= 1'b1;
      an_reg        <= '1;
      fd_reg        <= 1'b0;
    end else begin
      disp_reg      <= disp_next;
      dpm_reg       <= dpm_next;
      pend_full_reg <= (pend_full_reg & ~boundary) | xfer;
      if (xfer) begin
        pend_data_reg <= ld.load_data;
        pend_dp_reg   <= ld.load_dp;
      end
      nib_reg    <= nib_next;
      dp_out_reg <= dp_out_next;
      an_reg     <= an_next;
      fd_reg     <= boundary;
    end
  end

  assign ld.load_ready = ~pend_full_reg;
  assign digit_nib     = nib_reg;
  assign dp            = dp_out_reg;
  assign an            = an_reg;
  assign frame_done    = fd_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: two instances (guard 1 and guard 0) checked each cycle
// against a time-arithmetic model, plus literal checkpoints from the scan timeline.
module tb_seven_seg_scan_ctrl;
  import scan_pkg::*;

  localparam int N  = 4;
  localparam int DC = 4;

  typedef struct packed {
    logic [31:0] t;
    logic [15:0] disp;
    logic [3:0]  dpm;
    logic [15:0] pdata;
    logic [3:0]  pdp;
    logic        pfull;
    logic [3:0]  an;
    logic [3:0]  nib;
    logic        dp;
    logic        fd;
    logic        ready;
  } model_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N-1:0] blank_mask;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) ld_a ();
  seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) ld_b ();

  assign ld_b.load_valid = ld_a.load_valid;
  assign ld_b.load_data  = ld_a.load_data;
  assign ld_b.load_dp    = ld_a.load_dp;

  logic [3:0]   nib_a, nib_b;
  logic [N-1:0] an_a, an_b;
  logic         dp_a, dp_b, fd_a, fd_b;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_CYCLES(DC), .GUARD_CYCLES(1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld         (ld_a),
    .blank_mask (blank_mask),
    .digit_nib  (nib_a),
    .an         (an_a),
    .dp         (dp_a),
    .frame_done (fd_a)
  );

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_CYCLES(DC), .GUARD_CYCLES(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld         (ld_b),
    .blank_mask (blank_mask),
    .digit_nib  (nib_b),
    .an         (an_b),
    .dp         (dp_b),
    .frame_done (fd_b)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Edge t after reset: slot k = t / (DC+G); a slot's drive starts at remainder G,
  // its guard at remainder 0; frames end every N*(DC+G) edges.
  function automatic model_t model_step(input model_t m, input int g, input logic rst,
                                        input logic valid, input logic [15:0] data,
                                        input logic [3:0] ldp, input logic [3:0] blank);
    model_t n;
    int p, tn, k, r, d;
    n = m;
    if (!rst) begin
      n.t = 0; n.disp = '0; n.dpm = '0; n.pfull = 1'b0;
      n.an = 4'hF; n.nib = 4'h0; n.dp = 1'b1; n.fd = 1'b0; n.ready = 1'b1;
      return n;
    end
    p    = DC + g;
    tn   = int'(m.t) + 1;
    n.t  = 32'(tn);
    n.fd = ((tn % (N * p)) == 0);
    if (n.fd && m.pfull) begin
      n.disp = m.pdata;
      n.dpm  = m.pdp;
    end
    n.pfull = (m.pfull && !n.fd) || (valid && !m.pfull);
    if (valid && !m.pfull) begin
      n.pdata = data;
      n.pdp   = ldp;
    end
    n.ready = !n.pfull;
    k = tn / p;
    r = tn % p;
    d = k % N;
    if (r == g) begin
      n.nib = n.disp[4*d +: 4];
      n.dp  = ~n.dpm[d];
      n.an  = blank[d] ? 4'hF : ~(4'b0001 << d);
    end else if (r == 0) begin
      n.an = 4'hF;
    end
    return n;
  endfunction

  model_t ma, mb;
  bit     armed = 1'b0;
  bit     acc_a = 1'b0;

  always @(posedge clk) begin
    ma    <= model_step(ma, 1, rst_n, ld_a.load_valid, ld_a.load_data, ld_a.load_dp, blank_mask);
    mb    <= model_step(mb, 0, rst_n, ld_a.load_valid, ld_a.load_data, ld_a.load_dp, blank_mask);
    armed <= 1'b1;
    acc_a <= rst_n & ld_a.load_valid & ld_a.load_ready;
    if (rst_n && ld_a.load_valid && ld_a.load_ready)
      $display("[TB] load accepted data=%h dp=%b at %0t", ld_a.load_data, ld_a.load_dp, $time);
  end

  always @(negedge clk) begin
    if (armed) begin
      check("an_a",    32'(an_a),          32'(ma.an));
      check("nib_a",   32'(nib_a),         32'(ma.nib));
      check("dp_a",    32'(dp_a),          32'(ma.dp));
      check("fd_a",    32'(fd_a),          32'(ma.fd));
      check("ready_a", 32'(ld_a.load_ready), 32'(ma.ready));
      check("an_b",    32'(an_b),          32'(mb.an));
      check("nib_b",   32'(nib_b),         32'(mb.nib));
      check("dp_b",    32'(dp_b),          32'(mb.dp));
      check("fd_b",    32'(fd_b),          32'(mb.fd));
      check("ready_b", 32'(ld_b.load_ready), 32'(mb.ready));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    blank_mask      = '0;
    ld_a.load_valid = 1'b0;
    ld_a.load_data  = '0;
    ld_a.load_dp    = '0;
    repeat (2) @(negedge clk);
    check("rst_an",    32'(an_a), 32'hF);
    check("rst_dp",    32'(dp_a), 32'h1);
    check("rst_nib",   32'(nib_a), 32'h0);
    check("rst_ready", 32'(ld_a.load_ready), 32'h1);
    check("rst_fd",    32'(fd_a), 32'h0);
    check("rst_an_b",  32'(an_b), 32'hF);
    rst_n = 1'b1;
    @(negedge clk);                       // t=1
    check("t1_an", 32'(an_a), 32'hE);
    repeat (4) @(negedge clk);            // t=5
    check("t5_an", 32'(an_a), 32'hF);
    @(negedge clk);                       // t=6
    check("t6_an", 32'(an_a), 32'hD);
    ld_a.load_valid = 1'b1;
    ld_a.load_data  = 16'h1234;
    ld_a.load_dp    = 4'b0001;
    @(negedge clk);                       // t=7
    check("t7_ready", 32'(ld_a.load_ready), 32'h0);
    check("t7_nib",   32'(nib_a), 32'h0);
    ld_a.load_valid = 1'b0;
    repeat (13) @(negedge clk);           // t=20
    check("t20_fd",    32'(fd_a), 32'h1);
    check("t20_ready", 32'(ld_a.load_ready), 32'h1);
    @(negedge clk);                       // t=21
    check("t21_nib", 32'(nib_a), 32'h4);
    check("t21_dp",  32'(dp_a), 32'h0);
    check("t21_an",  32'(an_a), 32'hE);
    repeat (5) @(negedge clk);            // t=26
    check("t26_nib", 32'(nib_a), 32'h3);
    check("t26_dp",  32'(dp_a), 32'h1);
    ld_a.load_valid = 1'b1;
    ld_a.load_data  = 16'hABCD;
    ld_a.load_dp    = 4'b0000;
    @(negedge clk);                       // t=27, ABCD taken
    ld_a.load_data  = 16'h5678;
    repeat (13) @(negedge clk);           // t=40
    check("t40_ready", 32'(ld_a.load_ready), 32'h1);
    check("t40_fd",    32'(fd_a), 32'h1);
    @(negedge clk);                       // t=41, 5678 taken
    check("t41_nib",   32'(nib_a), 32'hD);
    check("t41_ready", 32'(ld_a.load_ready), 32'h0);
    ld_a.load_valid = 1'b0;
    blank_mask      = 4'b0100;
    repeat (10) @(negedge clk);           // t=51, digit 2 slot
    check("t51_blank_an", 32'(an_a), 32'hF);
    repeat (5) @(negedge clk);            // t=56, digit 3 slot
    check("t56_an", 32'(an_a), 32'h7);
    blank_mask = 4'b0000;
    repeat (11) @(negedge clk);           // t=67, mid digit 1 slot
    blank_mask = 4'b0010;
    @(negedge clk);                       // t=68
    check("t68_an", 32'(an_a), 32'hD);
    repeat (3) @(negedge clk);            // t=71, digit 2 slot
    check("t71_an", 32'(an_a), 32'hB);
    blank_mask      = 4'b0000;
    ld_a.load_valid = 1'b1;
    ld_a.load_data  = 16'h9999;
    ld_a.load_dp    = 4'b1111;
    @(negedge clk);                       // t=72, 9999 pending
    ld_a.load_valid = 1'b0;
    rst_n           = 1'b0;
    @(negedge clk);
    check("mid_rst_an",    32'(an_a), 32'hF);
    check("mid_rst_nib",   32'(nib_a), 32'h0);
    check("mid_rst_dp",    32'(dp_a), 32'h1);
    check("mid_rst_ready", 32'(ld_a.load_ready), 32'h1);
    rst_n = 1'b1;
    repeat (21) @(negedge clk);           // t=21 of new run
    check("post_rst_nib", 32'(nib_a), 32'h0);
    check("post_rst_dp",  32'(dp_a), 32'h1);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 9) == 0) blank_mask = 4'($urandom_range(0, 15));
      if (ld_a.load_valid && acc_a) ld_a.load_valid = 1'b0;
      if (!ld_a.load_valid && $urandom_range(0, 5) == 0) begin
        ld_a.load_valid = 1'b1;
        ld_a.load_data  = 16'($urandom);
        ld_a.load_dp    = 4'($urandom_range(0, 15));
      end
      rst_n = ($urandom_range(0, 799) != 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
